// File: rtl/cordic_result_fifo_if.sv
// Handshake bundle between the CORDIC issue side, the result FIFO and its consumer.
// The master drives samples and consumer readiness; the slave is the result FIFO.
interface cordic_result_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  logic                         issue_valid;
  logic                         issue_ready;
  logic [DATA_WIDTH-1:0]        pipe_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [$clog2(DEPTH+1)-1:0]   level;

  modport master (
    output issue_valid, pipe_data, out_ready,
    input  issue_ready, out_valid, out_data, level
  );

  modport slave (
    input  issue_valid, pipe_data, out_ready,
    output issue_ready, out_valid, out_data, level
  );
endinterface

// File: rtl/cordic_result_fifo.sv
// Captures results from a fixed-latency CORDIC pipeline into a credit-gated FIFO.
// Optional sticky protocol-violation flag `err` is enabled by defining CORDIC_FIFO_ERR_EN.
module cordic_result_fifo #(
  parameter int LATENCY    = 16,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cordic_result_fifo_if.slave   bus
`ifdef CORDIC_FIFO_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LATENCY + 1);
  localparam int SW = ((LW > IW) ? LW : IW) + 1;

  logic [LATENCY-1:0]    tag_q, tag_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  issue_ready;
  logic                  out_valid;
  logic                  issue;
  logic                  cap;
  logic                  pop;
  logic [SW-1:0]         credit_sum;

  // Stored plus in-flight results reserve a FIFO slot each, so a capture can never overflow.
  always_comb begin
    credit_sum  = SW'(level_q) + SW'(inflight_q);
    issue_ready = (credit_sum < SW'(DEPTH));
    issue       = bus.issue_valid & issue_ready;
    cap         = tag_q[LATENCY-1];
    out_valid   = (level_q != '0);
    pop         = out_valid & bus.out_ready;

    tag_d    = tag_q << 1;
    tag_d[0] = issue;

    inflight_d = inflight_q;
    case ({issue, cap})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    wr_ptr_d = cap ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({cap, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem[wr_ptr_q] <= bus.pipe_data;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_valid ? mem[rd_ptr_q] : '0;
  assign bus.level       = level_q;

`ifdef CORDIC_FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (bus.issue_valid & ~issue_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

  a_credit_bound: assert property (@(posedge clk) disable iff (rst) credit_sum <= SW'(DEPTH));

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Directed bench for cordic_result_fifo with a behavioural 16-stage CORDIC delay line.
// Build with CORDIC_FIFO_ERR_EN defined to also exercise the err flag.
module tb_cordic_result_fifo;

  localparam int LAT = 16;
  localparam int DEP = 8;
  localparam int DW  = 32;

  logic clk;
  logic rst;
  logic [DW-1:0] in_sample;
  logic [DW-1:0] pm [LAT];
  int vectors;
  int errors;
`ifdef CORDIC_FIFO_ERR_EN
  logic err;
`endif

  cordic_result_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

  cordic_result_fifo #(.LATENCY(LAT), .DEPTH(DEP), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef CORDIC_FIFO_ERR_EN
    ,
    .err (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the CORDIC pipeline: whatever is on its input emerges LAT edges later.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pm[i] <= pm[i-1];
    pm[0] <= in_sample;
  end
  assign bus.pipe_data = pm[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b0;
    in_sample       = '0;
    rst             = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if ({bus.out_valid, bus.out_data, bus.level, bus.issue_ready} !== {1'b0, 32'h0, 4'd0, 1'b1}) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got valid=%b data=%h level=%0d ready=%b, want 0/00000000/0/1",
                 c, bus.out_valid, bus.out_data, bus.level, bus.issue_ready);
      end
      tick();
    end
  endtask

  task automatic test_single();
    bus.out_ready   = 1'b0;
    bus.issue_valid = 1'b1;
    in_sample       = 32'h3F80_0000;
    tick();
    bus.issue_valid = 1'b0;
    in_sample       = '0;
    for (int e = 1; e < LAT; e++) tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.level !== 4'd0) begin
      errors++;
      $display("FAIL single_early: got valid=%b level=%0d, want 0/0", bus.out_valid, bus.level);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h3F80_0000 || bus.level !== 4'd1) begin
      errors++;
      $display("FAIL single_capture: got valid=%b data=%h level=%0d, want 1/3f800000/1",
               bus.out_valid, bus.out_data, bus.level);
    end
    tick();
    vectors++;
    if (bus.out_data !== 32'h3F80_0000 || bus.level !== 4'd1) begin
      errors++;
      $display("FAIL single_hold: got data=%h level=%0d, want 3f800000/1", bus.out_data, bus.level);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.level !== 4'd0) begin
      errors++;
      $display("FAIL single_pop: got valid=%b data=%h level=%0d, want 0/00000000/0",
               bus.out_valid, bus.out_data, bus.level);
    end
  endtask

  task automatic test_fill();
    int acc;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.issue_valid = 1'b1;
      in_sample       = 32'd100 + acc;
      if (bus.issue_ready === 1'b1) acc++;
      tick();
    end
    bus.issue_valid = 1'b0;
    in_sample       = '0;
    vectors++;
    if (acc != DEP) begin
      errors++;
      $display("FAIL fill_accepts: got %0d accepted, want %0d", acc, DEP);
    end
    for (int c = 0; c < LAT + 2; c++) tick();
    vectors++;
    if (bus.level !== 4'd8 || bus.issue_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got level=%0d ready=%b valid=%b, want 8/0/1",
               bus.level, bus.issue_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < DEP; j++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd100 + j) begin
        errors++;
        $display("FAIL fill_drain[%0d]: got valid=%b data=%0d, want 1/%0d",
                 j, bus.out_valid, bus.out_data, 100 + j);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty: got level=%0d valid=%b, want 0/0", bus.level, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    int rx;
    int cyc;
    int over;
    acc  = 0;
    rx   = 0;
    over = 0;
    bus.out_ready = 1'b0;
    while (acc < DEP) begin
      bus.issue_valid = 1'b1;
      in_sample       = 32'd1 + acc;
      if (bus.issue_ready === 1'b1) acc++;
      tick();
    end
    bus.issue_valid = 1'b0;
    for (int c = 0; c < LAT + 2; c++) tick();
    vectors++;
    if (bus.level !== 4'd8) begin
      errors++;
      $display("FAIL b2b_prefill: got level=%0d, want 8", bus.level);
    end
    bus.out_ready = 1'b1;
    cyc = 0;
    while (rx < 40 && cyc < 400) begin
      if (bus.out_valid === 1'b1) begin
        vectors++;
        if (bus.out_data !== 32'd1 + rx) begin
          errors++;
          $display("FAIL b2b_order[%0d]: got %0d, want %0d", rx, bus.out_data, rx + 1);
        end
        rx++;
      end
      if (bus.level > 4'd8) over++;
      if (acc < 40) begin
        bus.issue_valid = 1'b1;
        in_sample       = 32'd1 + acc;
        if (bus.issue_ready === 1'b1) acc++;
      end else begin
        bus.issue_valid = 1'b0;
        in_sample       = '0;
      end
      tick();
      cyc++;
    end
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b0;
    in_sample       = '0;
    vectors++;
    if (rx != 40) begin
      errors++;
      $display("FAIL b2b_count: got %0d results in %0d cycles, want 40", rx, cyc);
    end
    vectors++;
    if (over != 0) begin
      errors++;
      $display("FAIL b2b_level_bound: got %0d cycles with level>8, want 0", over);
    end
    tick();
    vectors++;
    if (bus.level !== 4'd0 || bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got level=%0d ready=%b, want 0/1", bus.level, bus.issue_ready);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.issue_valid = 1'b1;
      in_sample       = 32'hA1 + k;
      tick();
    end
    bus.issue_valid = 1'b0;
    in_sample       = '0;
    for (int c = 0; c < LAT; c++) tick();
    vectors++;
    if (bus.level !== 4'd3) begin
      errors++;
      $display("FAIL midrst_stored: got level=%0d, want 3", bus.level);
    end
    for (int k = 0; k < 5; k++) begin
      bus.issue_valid = 1'b1;
      in_sample       = 32'hB1 + k;
      tick();
    end
    bus.issue_valid = 1'b0;
    in_sample       = '0;
    tick();
    tick();
    do_reset();
    vectors++;
    if (bus.level !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_cleared: got level=%0d valid=%b data=%h ready=%b, want 0/0/00000000/1",
               bus.level, bus.out_valid, bus.out_data, bus.issue_ready);
    end
    for (int c = 0; c < LAT + 4; c++) tick();
    vectors++;
    if (bus.level !== 4'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late: got level=%0d valid=%b, want 0/0", bus.level, bus.out_valid);
    end
  endtask

`ifdef CORDIC_FIFO_ERR_EN
  task automatic test_err();
    do_reset();
    vectors++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got %b, want 0", err);
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEP; k++) begin
      bus.issue_valid = 1'b1;
      in_sample       = 32'hC0 + k;
      tick();
    end
    bus.issue_valid = 1'b0;
    vectors++;
    if (err !== 1'b0 || bus.issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_legal: got err=%b ready=%b, want 0/0", err, bus.issue_ready);
    end
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    vectors++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b, want 1", err);
    end
    for (int c = 0; c < 5; c++) tick();
    vectors++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, want 1", err);
    end
    do_reset();
    vectors++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b, want 0", err);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    errors  = 0;
    rst             = 1'b1;
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b0;
    in_sample       = '0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_reset_mid();
`ifdef CORDIC_FIFO_ERR_EN
    test_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
